// File: rtl/colouring_verifier.sv
// Checks a packed 3-colouring of the nine-vertex triadic_cascade graph, one edge per clock,
// stopping at the first improperly coloured edge and holding the result for the consumer.
module colouring_verifier #(
    parameter int NODES  = 9,
    parameter int EDGES  = 15,
    parameter int EDGE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*NODES-1:0]   in_colouring,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_pass,
    output logic                 out_bad_colour,
    output logic [EDGE_W-1:0]    out_fail_edge,
    output logic [EDGE_W-1:0]    out_cycles,
    output logic [2*NODES-1:0]   out_colouring
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state;
    logic [EDGE_W-1:0]   edge_idx;
    logic [3:0]          vertex_a;
    logic [3:0]          vertex_b;
    logic [1:0]          colour_a;
    logic [1:0]          colour_b;
    logic                edge_bad_colour;
    logic                edge_fail;
    logic                last_edge;

    // Fixed edge ROM for the triadic_cascade graph
    always_comb begin
        vertex_a = 4'd0;
        vertex_b = 4'd0;
        case (edge_idx)
            4'd0:    begin vertex_a = 4'd0; vertex_b = 4'd1; end
            4'd1:    begin vertex_a = 4'd0; vertex_b = 4'd2; end
            4'd2:    begin vertex_a = 4'd0; vertex_b = 4'd4; end
            4'd3:    begin vertex_a = 4'd0; vertex_b = 4'd5; end
            4'd4:    begin vertex_a = 4'd1; vertex_b = 4'd2; end
            4'd5:    begin vertex_a = 4'd1; vertex_b = 4'd3; end
            4'd6:    begin vertex_a = 4'd1; vertex_b = 4'd5; end
            4'd7:    begin vertex_a = 4'd2; vertex_b = 4'd3; end
            4'd8:    begin vertex_a = 4'd2; vertex_b = 4'd4; end
            4'd9:    begin vertex_a = 4'd3; vertex_b = 4'd7; end
            4'd10:   begin vertex_a = 4'd3; vertex_b = 4'd8; end
            4'd11:   begin vertex_a = 4'd4; vertex_b = 4'd6; end
            4'd12:   begin vertex_a = 4'd4; vertex_b = 4'd8; end
            4'd13:   begin vertex_a = 4'd5; vertex_b = 4'd6; end
            4'd14:   begin vertex_a = 4'd5; vertex_b = 4'd7; end
            default: begin vertex_a = 4'd0; vertex_b = 4'd0; end
        endcase
    end

    always_comb begin
        colour_a        = out_colouring[{vertex_a, 1'b0} +: 2];
        colour_b        = out_colouring[{vertex_b, 1'b0} +: 2];
        edge_bad_colour = (colour_a == 2'd3) || (colour_b == 2'd3);
        edge_fail       = (colour_a == colour_b) || edge_bad_colour;
        last_edge       = (edge_idx == EDGE_W'(EDGES - 1));
    end

    // Ready is gated by reset so nothing is accepted while the block is held in reset
    assign in_ready = reset_n && (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            edge_idx       <= '0;
            out_valid      <= 1'b0;
            out_pass       <= 1'b0;
            out_bad_colour <= 1'b0;
            out_fail_edge  <= '0;
            out_cycles     <= '0;
            out_colouring  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_colouring  <= in_colouring;
                        edge_idx       <= '0;
                        out_pass       <= 1'b0;
                        out_bad_colour <= 1'b0;
                        out_fail_edge  <= '0;
                        out_cycles     <= '0;
                        state          <= CHECK;
                    end
                end
                CHECK: begin
                    out_cycles <= edge_idx + EDGE_W'(1);
                    if (edge_fail) begin
                        out_pass       <= 1'b0;
                        out_fail_edge  <= edge_idx;
                        out_bad_colour <= edge_bad_colour;
                        out_valid      <= 1'b1;
                        state          <= REPORT;
                    end else if (last_edge) begin
                        out_pass      <= 1'b1;
                        out_fail_edge <= EDGE_W'(EDGES);
                        out_valid     <= 1'b1;
                        state         <= REPORT;
                    end else begin
                        edge_idx <= edge_idx + EDGE_W'(1);
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_colouring_verifier.sv
// Directed bench for colouring_verifier: known colourings with hand-derived verdicts,
// back-pressure on the result, and reset during a check.
module tb_colouring_verifier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_colouring;
    logic        out_valid;
    logic        out_ready;
    logic        out_pass;
    logic        out_bad_colour;
    logic [3:0]  out_fail_edge;
    logic [3:0]  out_cycles;
    logic [17:0] out_colouring;

    int compared   = 0;
    int mismatched = 0;
    int latency;

    always #5 clk = ~clk;

    colouring_verifier dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_colouring   (in_colouring),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pass       (out_pass),
        .out_bad_colour (out_bad_colour),
        .out_fail_edge  (out_fail_edge),
        .out_cycles     (out_cycles),
        .out_colouring  (out_colouring)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one colouring, then scrambles the input bus and counts edges until out_valid
    task automatic apply_stimulus(input logic [17:0] colouring, output int edges);
        @(negedge clk);
        in_colouring = colouring;
        in_valid     = 1'b1;
        check_output("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_colouring = 18'h3ffff;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int edges, input int exp_edges,
                                input logic exp_pass, input logic exp_bad,
                                input logic [3:0] exp_fail, input logic [3:0] exp_cycles,
                                input logic [17:0] exp_colouring);
        check_output({tag, "_latency"},    32'(edges),          32'(exp_edges));
        check_output({tag, "_out_valid"},  32'(out_valid),      32'd1);
        check_output({tag, "_in_ready"},   32'(in_ready),       32'd0);
        check_output({tag, "_pass"},       32'(out_pass),       32'(exp_pass));
        check_output({tag, "_bad_colour"}, 32'(out_bad_colour), 32'(exp_bad));
        check_output({tag, "_fail_edge"},  32'(out_fail_edge),  32'(exp_fail));
        check_output({tag, "_cycles"},     32'(out_cycles),     32'(exp_cycles));
        check_output({tag, "_colouring"},  32'(out_colouring),  32'(exp_colouring));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
        check_output({tag, "_ready_back"},    32'(in_ready),  32'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_colouring = '0;
        out_ready    = 1'b0;
        #12;
        check_output("reset_out_valid", 32'(out_valid),     32'd0);
        check_output("reset_in_ready",  32'(in_ready),      32'd0);
        check_output("reset_pass",      32'(out_pass),      32'd0);
        check_output("reset_colouring", 32'(out_colouring), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_output("reset_release_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] T1 proper colouring");
        apply_stimulus(18'h24924, latency);
        check_result("t1", latency, 15, 1'b1, 1'b0, 4'd15, 4'd15, 18'h24924);
        release_result("t1");

        $display("[TB] T2 all red");
        apply_stimulus(18'h00000, latency);
        check_result("t2", latency, 1, 1'b0, 1'b0, 4'd0, 4'd1, 18'h00000);
        release_result("t2");

        $display("[TB] T3 vertex 8 illegal");
        apply_stimulus(18'h34924, latency);
        check_result("t3", latency, 11, 1'b0, 1'b1, 4'd10, 4'd11, 18'h34924);
        release_result("t3");

        $display("[TB] T4 clash on last edge");
        apply_stimulus(18'h28924, latency);
        check_result("t4", latency, 15, 1'b0, 1'b0, 4'd14, 4'd15, 18'h28924);
        release_result("t4");
        check_output("t4_idle_hold_fail_edge", 32'(out_fail_edge), 32'd14);

        $display("[TB] T5 back-pressure on result");
        apply_stimulus(18'h24924, latency);
        check_result("t5", latency, 15, 1'b1, 1'b0, 4'd15, 4'd15, 18'h24924);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("t5_hold_valid",     32'(out_valid),     32'd1);
            check_output("t5_hold_in_ready",  32'(in_ready),      32'd0);
            check_output("t5_hold_pass",      32'(out_pass),      32'd1);
            check_output("t5_hold_fail_edge", 32'(out_fail_edge), 32'd15);
        end
        release_result("t5");

        $display("[TB] T6 reset during check");
        @(negedge clk);
        in_colouring = 18'h24924;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("t6_reset_valid",     32'(out_valid),     32'd0);
        check_output("t6_reset_in_ready",  32'(in_ready),      32'd0);
        check_output("t6_reset_cycles",    32'(out_cycles),    32'd0);
        check_output("t6_reset_colouring", 32'(out_colouring), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_output("t6_release_in_ready", 32'(in_ready), 32'd1);
        apply_stimulus(18'h00000, latency);
        check_result("t6_t2", latency, 1, 1'b0, 1'b0, 4'd0, 4'd1, 18'h00000);
        release_result("t6_t2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
